// File: rtl/data_memory_responder_pkg.sv
// Shared types and helpers for the data-memory load/store responder.
// Holds the FSM state type, the word width and the address error rule.
package mem_if_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] ALIGN_MASK = 32'h0000_0003;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Misaligned, or any bit set above the word-index field.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned addr_w);
        logic [WORD_W-1:0] high_mask;
        high_mask = ~((WORD_W'(1) << (addr_w + 2)) - WORD_W'(1));
        return ((addr & ALIGN_MASK) != '0) || ((addr & high_mask) != '0);
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Load/store request/response bundle between the memory-access stage
// (master) and the data-memory responder (slave).
interface data_memory_responder_if;
    import mem_if_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              resp_err;
    logic              busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );

endinterface

// File: rtl/data_memory_responder_dm_array.sv
// Single-port DEPTH x 32 synchronous word RAM with a registered read port.
// The read register only updates on enabled loads.
module dm_array
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[index] <= wdata;
            end else begin
                rdata <= mem[index];
            end
        end
    end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: accepts one load/store at a time, performs it on an
// internal word array after LATENCY edges, and returns a one-cycle response.
module data_memory_responder
    import mem_if_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    data_memory_responder_if.slave   bus
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              cap_we;
    logic              cap_err;
    logic [ADDR_W-1:0] cap_index;
    logic [WORD_W-1:0] cap_wdata;
    logic              load_ok;
    logic [WORD_W-1:0] ram_rdata;
    logic              access;
    logic              ram_en;

    assign access = (state == WAIT) && (cnt == '0);
    // Reset on the access edge must suppress the write, so gate the enable directly.
    assign ram_en = access && !cap_err && !reset;

    dm_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .en    (ram_en),
        .we    (cap_we),
        .index (cap_index),
        .wdata (cap_wdata),
        .rdata (ram_rdata)
    );

    assign bus.resp_rdata = load_ok ? ram_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            cap_we         <= 1'b0;
            cap_err        <= 1'b0;
            cap_index      <= '0;
            cap_wdata      <= '0;
            load_ok        <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    load_ok        <= 1'b0;
                    if (bus.req_valid) begin
                        state         <= WAIT;
                        cnt           <= CNT_INIT;
                        cap_we        <= bus.req_we;
                        cap_err       <= addr_err(bus.req_addr, ADDR_W);
                        cap_index     <= bus.req_addr[ADDR_W+1:2];
                        cap_wdata     <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= cap_err;
                        load_ok        <= !cap_we && !cap_err;
                        bus.req_ready  <= 1'b1;
                        bus.busy       <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: a word-array reference model
// predicts every response; a second instance checks the LATENCY=1 build.
module tb_data_memory_responder;
    import mem_if_pkg::*;

    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned LAT    = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_memory_responder_if bus ();
    data_memory_responder_if bus1 ();

    data_memory_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LAT)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    data_memory_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] model [int unsigned];

    function automatic bit ref_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'(4 * DEPTH));
    endfunction

    // Expected response for one transaction; applies stores to the model.
    function automatic logic [31:0] ref_apply(input logic we, input logic [31:0] a, input logic [31:0] d);
        if (ref_err(a)) return 32'h0;
        if (we) begin
            model[a / 4] = d;
            return 32'h0;
        end
        return model[a / 4];
    endfunction

    // Drives one request on the LATENCY=2 instance, starting at a negedge.
    // Ends at the negedge where the response is seen, with req_valid low.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input bit hold,
                       output int stall, output int lat, output int busyc,
                       output logic [31:0] rdata, output logic err,
                       output logic [31:0] exp_rdata, output logic exp_err);
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        stall = 0; lat = 99; busyc = 0; rdata = 'x; err = 1'bx;
        exp_err   = ref_err(addr);
        exp_rdata = 32'h0;
        while (bus.req_ready !== 1'b1 && stall < 20) begin
            @(negedge clk);
            stall++;
        end
        if (stall >= 20) begin
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_rdata = ref_apply(we, addr, wdata);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) begin
                lat   = k;
                rdata = bus.resp_rdata;
                err   = bus.resp_err;
                break;
            end
            if (bus.busy === 1'b1 && bus.req_ready === 1'b0) busyc++;
            if (hold) begin
                bus.req_addr  = 32'h44 + 32'(4 * ($urandom % 2));
                bus.req_wdata = $urandom;
            end else begin
                bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b0;  bus.req_we = 1'b0;  bus.req_addr = '0;  bus.req_wdata = '0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.busy} !== 4'b1000 || bus.resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready/valid/err/busy=%b rdata=%h, want 1000 rdata=0",
                     {bus.req_ready, bus.resp_valid, bus.resp_err, bus.busy}, bus.resp_rdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        int st, lat, bc; logic [31:0] rd, er; logic e, ee;
        txn(1'b1, 32'h0, 32'hDEADBEEF, 1'b0, st, lat, bc, rd, e, er, ee);
        checks++;
        if (lat !== LAT || rd !== 32'h0 || e !== 1'b0) begin
            errors++;
            $display("FAIL store_resp: lat=%0d rdata=%h err=%b, want lat=%0d rdata=0 err=0", lat, rd, e, LAT);
        end
        @(negedge clk);
        txn(1'b0, 32'h0, 32'h0, 1'b0, st, lat, bc, rd, e, er, ee);
        checks++;
        if (lat !== LAT || rd !== er || e !== 1'b0) begin
            errors++;
            $display("FAIL load_resp: lat=%0d rdata=%h err=%b, want lat=%0d rdata=%h err=0", lat, rd, e, LAT, er);
        end
        @(negedge clk);
        checks++;
        if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== 32'h0 || bus.resp_err !== 1'b0) begin
            errors++;
            $display("FAIL resp_clear: valid=%b rdata=%h err=%b, want 0/0/0", bus.resp_valid, bus.resp_rdata, bus.resp_err);
        end
    endtask

    task automatic test_back_to_back();
        int st, lat, bc; logic [31:0] rd, er; logic e, ee;
        txn(1'b0, 32'h0, 32'h0, 1'b0, st, lat, bc, rd, e, er, ee);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_in_resp: req_ready=%b, want 1", bus.req_ready);
        end
        txn(1'b1, 32'h10, 32'h11111111, 1'b0, st, lat, bc, rd, e, er, ee);
        txn(1'b0, 32'h10, 32'h0, 1'b0, st, lat, bc, rd, e, er, ee);
        checks++;
        if (st !== 0 || lat !== LAT || rd !== 32'h11111111 || e !== 1'b0) begin
            errors++;
            $display("FAIL b2b_load: stall=%0d lat=%0d rdata=%h err=%b, want 0/%0d/11111111/0", st, lat, rd, e, LAT);
        end
        @(negedge clk);
    endtask

    task automatic test_errors();
        int st, lat, bc; logic [31:0] rd, er; logic e, ee;
        txn(1'b0, 32'h6, 32'h0, 1'b0, st, lat, bc, rd, e, er, ee);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0 || lat !== LAT) begin
            errors++;
            $display("FAIL misaligned_load: err=%b rdata=%h lat=%0d, want 1/0/%0d", e, rd, lat, LAT);
        end
        @(negedge clk);
        txn(1'b1, 32'h400, 32'hFFFFFFFF, 1'b0, st, lat, bc, rd, e, er, ee);
        checks++;
        if (e !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL range_store: err=%b rdata=%h, want 1/0", e, rd);
        end
        @(negedge clk);
        txn(1'b0, 32'h0, 32'h0, 1'b0, st, lat, bc, rd, e, er, ee);
        checks++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
            errors++;
            $display("FAIL no_corrupt: rdata=%h err=%b, want deadbeef/0", rd, e);
        end
        @(negedge clk);
    endtask

    task automatic test_hold_valid();
        int st, lat, bc; logic [31:0] rd, er; logic e, ee;
        logic [31:0] d;
        txn(1'b1, 32'h44, 32'h55AA55AA, 1'b0, st, lat, bc, rd, e, er, ee);
        txn(1'b1, 32'h48, 32'h66BB66BB, 1'b0, st, lat, bc, rd, e, er, ee);
        @(negedge clk);
        d = $urandom;
        txn(1'b1, 32'h30, d, 1'b1, st, lat, bc, rd, e, er, ee);
        checks++;
        if (bc !== LAT || lat !== LAT) begin
            errors++;
            $display("FAIL hold_busy: busy_cycles=%0d lat=%0d, want %0d/%0d", bc, lat, LAT, LAT);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_no_extra: busy=%b ready=%b, want 0/1", bus.busy, bus.req_ready);
        end
        txn(1'b0, 32'h30, 32'h0, 1'b0, st, lat, bc, rd, e, er, ee);
        checks++;
        if (rd !== d) begin
            errors++;
            $display("FAIL hold_captured: rdata=%h, want %h", rd, d);
        end
        @(negedge clk);
        txn(1'b0, 32'h44, 32'h0, 1'b0, st, lat, bc, rd, e, er, ee);
        txn(1'b0, 32'h48, 32'h0, 1'b0, st, lat, bc, rd, e, er, ee);
        checks++;
        if (rd !== 32'h66BB66BB || model[32'h44 / 4] !== 32'h55AA55AA) begin
            errors++;
            $display("FAIL hold_other_addr: rdata=%h, want 66bb66bb", rd);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int st, lat, bc; logic [31:0] rd, er; logic e, ee;
        int seen;
        txn(1'b1, 32'h20, 32'h12345678, 1'b0, st, lat, bc, rd, e, er, ee);
        @(negedge clk);
        bus.req_we = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'hCAFEF00D; bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.busy} !== 4'b1000 || bus.resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_state: ready/valid/err/busy=%b rdata=%h, want 1000 rdata=0",
                     {bus.req_ready, bus.resp_valid, bus.resp_err, bus.busy}, bus.resp_rdata);
        end
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_mid_noresp: responses=%0d, want 0", seen);
        end
        txn(1'b0, 32'h20, 32'h0, 1'b0, st, lat, bc, rd, e, er, ee);
        checks++;
        if (rd !== 32'h12345678) begin
            errors++;
            $display("FAIL reset_mid_nowrite: rdata=%h, want 12345678", rd);
        end
        @(negedge clk);
        reset = 1'b1;
        bus.req_we = 1'b0; bus.req_addr = 32'h0; bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.req_valid = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.resp_valid === 1'b1 || bus.busy === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_with_valid: busy/resp cycles=%0d, want 0", seen);
        end
    endtask

    task automatic test_random();
        int st, lat, bc; logic [31:0] rd, er; logic e, ee;
        logic [31:0] a;
        logic w;
        int bad;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom % 8)
                0:       a = 32'($urandom % 16) * 4 + 32'($urandom_range(1, 3));
                1:       a = $urandom | 32'h400;
                default: a = 32'($urandom % 16) * 4;
            endcase
            w = 1'($urandom % 2);
            if (!ref_err(a) && !model.exists(a / 4)) w = 1'b1;
            txn(w, a, $urandom, 1'b0, st, lat, bc, rd, e, er, ee);
            checks++;
            if (lat !== LAT || rd !== er || e !== ee) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL random_txn%0d: we=%b addr=%h lat=%0d rdata=%h err=%b, want lat=%0d rdata=%h err=%b",
                             i, w, a, lat, rd, e, LAT, er, ee);
            end
            if ($urandom % 2) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_latency1();
        int resps;
        bus1.req_we = 1'b1; bus1.req_addr = 32'h8; bus1.req_wdata = 32'h0BADF00D; bus1.req_valid = 1'b1;
        resps = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus1.resp_valid === 1'b1) resps++;
        end
        bus1.req_valid = 1'b0;
        checks++;
        if (resps !== 10) begin
            errors++;
            $display("FAIL lat1_stream: responses=%0d in 20 cycles, want 10", resps);
        end
        @(negedge clk);
        bus1.req_we = 1'b0; bus1.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        checks++;
        if (bus1.resp_valid !== 1'b0 || bus1.busy !== 1'b1) begin
            errors++;
            $display("FAIL lat1_wait: valid=%b busy=%b after E0, want 0/1", bus1.resp_valid, bus1.busy);
        end
        @(negedge clk);
        checks++;
        if (bus1.resp_valid !== 1'b1 || bus1.resp_rdata !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL lat1_load: valid=%b rdata=%h after E1, want 1/0badf00d", bus1.resp_valid, bus1.resp_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_errors();
        test_hold_valid();
        test_reset_mid();
        test_random();
        test_latency1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
